// File: rtl/cfg_cmd_decoder.sv
// ---------------------------------------------------------------------------
// cfg_cmd_decoder
//
// Decodes configuration commands that arrive as received UDP payload words
// and turns them into register-bus write/read strobes. Every accepted
// command produces a response on the transmit FIFO:
//   write : rx cmd {01,x,addr}, rx data   -> wr pulse, tx {01,14'h0,addr}
//   read  : rx cmd {10,x,addr}            -> rd pulse, tx {10,14'h0,addr},
//                                            tx read data
// Illegal opcodes (00/11) and words that arrive while a transaction is in
// progress are dropped and counted in a saturating error counter.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   rx_ready   in   strobe: rx_data holds a valid payload word
//   rx_data    in   [31:0] payload word
//   tx_full    in   response FIFO full flag
//   tx_wr      out  response FIFO write strobe (only while tx_full=0)
//   tx_data    out  [31:0] response word
//   address    out  [15:0] register address
//   wr         out  one-cycle register write strobe
//   rd         out  one-cycle register read strobe
//   dout       out  [31:0] register write data
//   din        in   [31:0] register read data, RD_LATENCY cycles after rd
//   err_count  out  [7:0] saturating count of illegal/dropped words
// ---------------------------------------------------------------------------
module cfg_cmd_decoder #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [31:0] rx_data,
    input  logic        tx_full,
    output logic        tx_wr,
    output logic [31:0] tx_data,
    output logic [15:0] address,
    output logic        wr,
    output logic        rd,
    output logic [31:0] dout,
    input  logic [31:0] din,
    output logic [7:0]  err_count
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_DATA   = 3'd1;
    localparam logic [2:0] WR_ACK    = 3'd2;
    localparam logic [2:0] RD_WAIT   = 3'd3;
    localparam logic [2:0] RESP_HDR  = 3'd4;
    localparam logic [2:0] RESP_DATA = 3'd5;

    // Counter values in RD_WAIT (counted from the cycle after rd rises):
    // din is captured at CAP_CNT, the header is staged one cycle later so
    // it appears RD_LATENCY+2 cycles after the rd pulse.
    localparam logic [2:0] CAP_CNT = 3'(RD_LATENCY);
    localparam logic [2:0] HDR_CNT = 3'(RD_LATENCY + 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] address_q, address_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;   // strobe (wr or rd) due on the next edge
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        err_inc;
    logic [1:0]  opcode;
    logic        emit;

    assign opcode = rx_data[31:30];

    // A response word is being offered this cycle. The write ack waits
    // until the wr pulse has been issued and has retired.
    assign emit = (state_q == RESP_HDR) || (state_q == RESP_DATA) ||
                  ((state_q == WR_ACK) && !pend_q && !wr_q);

    // Gated combinationally so a word is only offered while the FIFO has
    // room; the FSM advances on exactly the same condition.
    assign tx_wr = emit && !tx_full && !reset;

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        dout_d    = dout_q;
        tx_data_d = tx_data_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        err_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    case (opcode)
                        2'b01: begin
                            address_d = rx_data[15:0];
                            state_d   = WR_DATA;
                        end
                        2'b10: begin
                            address_d = rx_data[15:0];
                            pend_d    = 1'b1;
                            state_d   = RD_WAIT;
                        end
                        default: err_inc = 1'b1;
                    endcase
                end
            end
            WR_DATA: begin
                if (rx_ready) begin
                    dout_d  = rx_data;
                    pend_d  = 1'b1;
                    state_d = WR_ACK;
                end
            end
            WR_ACK: begin
                err_inc = rx_ready;
                if (pend_q) begin
                    wr_d      = 1'b1;
                    pend_d    = 1'b0;
                    tx_data_d = {2'b01, 14'h0, address_q};
                end else if (!wr_q && !tx_full) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                err_inc = rx_ready;
                if (pend_q) begin
                    rd_d   = 1'b1;
                    pend_d = 1'b0;
                    cnt_d  = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == CAP_CNT) begin
                        rdata_d = din;
                    end
                    if (cnt_q == HDR_CNT) begin
                        tx_data_d = {2'b10, 14'h0, address_q};
                        state_d   = RESP_HDR;
                    end
                end
            end
            RESP_HDR: begin
                err_inc = rx_ready;
                if (!tx_full) begin
                    tx_data_d = rdata_q;
                    state_d   = RESP_DATA;
                end
            end
            RESP_DATA: begin
                err_inc = rx_ready;
                if (!tx_full) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            address_q <= 16'h0;
            dout_q    <= 32'h0;
            tx_data_q <= 32'h0;
            err_q     <= 8'h0;
            cnt_q     <= 3'd0;
            pend_q    <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            dout_q    <= dout_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    // Read holding register: only meaningful after a capture, no reset.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign tx_data   = tx_data_q;
    assign address   = address_q;
    assign dout      = dout_q;
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_cfg_cmd_decoder.sv
module tb_cfg_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_ready = 1'b0;
    logic [31:0] rx_data = 32'h0;
    logic        tx_full = 1'b0;
    logic        tx_wr;
    logic [31:0] tx_data;
    logic [15:0] address;
    logic        wr;
    logic        rd;
    logic [31:0] dout;
    logic [31:0] din;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Register-bus model with a read latency of 1: din carries rd_val only
    // in the cycle after rd, garbage otherwise.
    logic        rd_d1 = 1'b0;
    logic [31:0] rd_val = 32'h0;
    assign din = rd_d1 ? rd_val : 32'hBAD0BAD0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_d1 <= rd;

    cfg_cmd_decoder #(.RD_LATENCY(1)) dut (
        .clk(clk),
        .reset(reset),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .tx_full(tx_full),
        .tx_wr(tx_wr),
        .tx_data(tx_data),
        .address(address),
        .wr(wr),
        .rd(rd),
        .dout(dout),
        .din(din),
        .err_count(err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_ready = 1'b0;
        tx_full = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (tx_wr !== 1'b0) begin n_bad++; $display("FAIL reset_tx_wr: got %b want 0", tx_wr); end
        n_cmp++; if ({wr, rd} !== 2'b00) begin n_bad++; $display("FAIL reset_wr_rd: got %b want 00", {wr, rd}); end
        n_cmp++; if (tx_data !== 32'h0) begin n_bad++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        n_cmp++; if (address !== 16'h0) begin n_bad++; $display("FAIL reset_address: got %h want 0", address); end
        n_cmp++; if (dout !== 32'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", dout); end
        n_cmp++; if (err_count !== 8'h0) begin n_bad++; $display("FAIL reset_err: got %h want 0", err_count); end
    endtask

    task automatic test_write();
        rx_ready = 1'b1; rx_data = 32'h40000012;
        tick();
        rx_data = 32'hDEADBEEF;
        tick();
        rx_ready = 1'b0; rx_data = 32'h0;
        n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL wr_early: got %b want 0", wr); end
        tick();
        n_cmp++; if (wr !== 1'b1) begin n_bad++; $display("FAIL wr_pulse: got %b want 1", wr); end
        n_cmp++; if (address !== 16'h0012) begin n_bad++; $display("FAIL wr_address: got %h want 0012", address); end
        n_cmp++; if (dout !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_dout: got %h want deadbeef", dout); end
        n_cmp++; if (tx_wr !== 1'b0) begin n_bad++; $display("FAIL wr_tx_early: got %b want 0", tx_wr); end
        tick();
        n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL wr_single: got %b want 0", wr); end
        n_cmp++; if (tx_wr !== 1'b1) begin n_bad++; $display("FAIL wr_ack_strobe: got %b want 1", tx_wr); end
        n_cmp++; if (tx_data !== 32'h40000012) begin n_bad++; $display("FAIL wr_ack_data: got %h want 40000012", tx_data); end
        tick();
        n_cmp++; if (tx_wr !== 1'b0) begin n_bad++; $display("FAIL wr_ack_single: got %b want 0", tx_wr); end
    endtask

    task automatic test_read();
        rd_val = 32'h12345678;
        rx_ready = 1'b1; rx_data = 32'h80000034;
        tick();
        rx_ready = 1'b0;
        n_cmp++; if (rd !== 1'b0) begin n_bad++; $display("FAIL rd_early: got %b want 0", rd); end
        tick();
        n_cmp++; if (rd !== 1'b1) begin n_bad++; $display("FAIL rd_pulse: got %b want 1", rd); end
        n_cmp++; if (address !== 16'h0034) begin n_bad++; $display("FAIL rd_address: got %h want 0034", address); end
        tick();
        n_cmp++; if (rd !== 1'b0) begin n_bad++; $display("FAIL rd_single: got %b want 0", rd); end
        tick();
        n_cmp++; if (tx_wr !== 1'b0) begin n_bad++; $display("FAIL rd_hdr_early: got %b want 0", tx_wr); end
        tick();
        n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 32'h80000034) begin n_bad++; $display("FAIL rd_hdr: got %b/%h want 1/80000034", tx_wr, tx_data); end
        tick();
        n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 32'h12345678) begin n_bad++; $display("FAIL rd_data: got %b/%h want 1/12345678", tx_wr, tx_data); end
        tick();
        n_cmp++; if (tx_wr !== 1'b0) begin n_bad++; $display("FAIL rd_done: got %b want 0", tx_wr); end
    endtask

    task automatic test_backpressure();
        int stall_tx;
        stall_tx = 0;
        rd_val = 32'hA5A5_0F0F;
        rx_ready = 1'b1; rx_data = 32'h80000056;
        tick();
        rx_ready = 1'b0;
        tick();  // rd pulse
        tick();
        tick();  // din captured
        tx_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_wr !== 1'b0) stall_tx++;
        end
        n_cmp++; if (stall_tx !== 0) begin n_bad++; $display("FAIL bp_stall_tx_wr: got %0d strobes want 0", stall_tx); end
        n_cmp++; if (tx_data !== 32'h80000056) begin n_bad++; $display("FAIL bp_hold_data: got %h want 80000056", tx_data); end
        tx_full = 1'b0;
        #1;
        n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 32'h80000056) begin n_bad++; $display("FAIL bp_hdr: got %b/%h want 1/80000056", tx_wr, tx_data); end
        tick();
        n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 32'hA5A50F0F) begin n_bad++; $display("FAIL bp_data: got %b/%h want 1/a5a50f0f", tx_wr, tx_data); end
        tick();
        n_cmp++; if (tx_wr !== 1'b0) begin n_bad++; $display("FAIL bp_done: got %b want 0", tx_wr); end
    endtask

    task automatic test_illegal_overrun();
        do_reset();
        rd_val = 32'hCAFEF00D;
        rx_ready = 1'b1; rx_data = 32'hC0000001;
        tick();
        rx_ready = 1'b0;
        n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL ill_err: got %0d want 1", err_count); end
        rx_ready = 1'b1; rx_data = 32'h80000078;
        tick();
        rx_data = 32'h40001111;   // arrives during RD_WAIT
        tick();
        rx_ready = 1'b0;
        n_cmp++; if (rd !== 1'b1 || address !== 16'h0078) begin n_bad++; $display("FAIL ovr_rd: got %b/%h want 1/0078", rd, address); end
        n_cmp++; if (err_count !== 8'd2) begin n_bad++; $display("FAIL ovr_err: got %0d want 2", err_count); end
        tick();
        tick();
        tick();
        n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 32'h80000078) begin n_bad++; $display("FAIL ovr_hdr: got %b/%h want 1/80000078", tx_wr, tx_data); end
        tick();
        n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 32'hCAFEF00D) begin n_bad++; $display("FAIL ovr_data: got %b/%h want 1/cafef00d", tx_wr, tx_data); end
        tick();
        n_cmp++; if (tx_wr !== 1'b0 || wr !== 1'b0 || err_count !== 8'd2) begin n_bad++; $display("FAIL ovr_after: got tx_wr=%b wr=%b err=%0d want 0/0/2", tx_wr, wr, err_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        rx_ready = 1'b1; rx_data = 32'h00000000;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) begin
                n_cmp++; if (err_count !== 8'hFE) begin n_bad++; $display("FAIL sat_254: got %h want fe", err_count); end
            end
        end
        rx_ready = 1'b0;
        tick();
        n_cmp++; if (err_count !== 8'hFF) begin n_bad++; $display("FAIL sat_final: got %h want ff", err_count); end
    endtask

    task automatic test_reset_mid_write();
        int wr_seen;
        wr_seen = 0;
        do_reset();
        rx_ready = 1'b1; rx_data = 32'h40000099;
        tick();               // now in WR_DATA
        rx_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (address !== 16'h0 || err_count !== 8'h0) begin n_bad++; $display("FAIL rst_mid_state: got addr=%h err=%0d want 0/0", address, err_count); end
        rx_ready = 1'b1; rx_data = 32'h11111111;
        tick();
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (wr !== 1'b0 || rd !== 1'b0) wr_seen++;
            tick();
        end
        n_cmp++; if (wr_seen !== 0) begin n_bad++; $display("FAIL rst_mid_no_wr: got %0d strobes want 0", wr_seen); end
        n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL rst_mid_err: got %0d want 1", err_count); end
        n_cmp++; if (dout !== 32'h0) begin n_bad++; $display("FAIL rst_mid_dout: got %h want 0", dout); end
    endtask

    task automatic test_reset_blocked();
        int tx_seen;
        tx_seen = 0;
        do_reset();
        rd_val = 32'h0BADF00D;
        rx_ready = 1'b1; rx_data = 32'h800000AB;
        tick();
        rx_ready = 1'b0;
        tick();
        tick();
        tick();
        tx_full = 1'b1;
        tick();
        tick();               // blocked in RESP_HDR
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tx_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (tx_wr !== 1'b0 || rd !== 1'b0 || wr !== 1'b0) tx_seen++;
            tick();
        end
        n_cmp++; if (tx_seen !== 0) begin n_bad++; $display("FAIL rst_blk_strobes: got %0d want 0", tx_seen); end
        n_cmp++; if (tx_data !== 32'h0) begin n_bad++; $display("FAIL rst_blk_tx_data: got %h want 0", tx_data); end
    endtask

    task automatic test_back_to_back();
        // Write immediately followed by a read command once IDLE is reached.
        do_reset();
        rd_val = 32'h55AA55AA;
        rx_ready = 1'b1; rx_data = 32'h40000100;
        tick();
        rx_data = 32'h00C0FFEE;
        tick();
        rx_ready = 1'b0;
        tick();               // wr pulse
        n_cmp++; if (wr !== 1'b1 || dout !== 32'h00C0FFEE) begin n_bad++; $display("FAIL b2b_wr: got %b/%h want 1/00c0ffee", wr, dout); end
        tick();               // write ack offered
        rx_ready = 1'b1; rx_data = 32'h80000200;
        tick();               // ack accepted, read cmd sampled
        rx_ready = 1'b0;
        n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL b2b_cmd_in_ack: got %0d want 1", err_count); end
        rx_ready = 1'b1;
        tick();               // IDLE now takes the read command
        rx_ready = 1'b0;
        tick();
        n_cmp++; if (rd !== 1'b1 || address !== 16'h0200) begin n_bad++; $display("FAIL b2b_rd: got %b/%h want 1/0200", rd, address); end
        tick();
        tick();
        tick();
        n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 32'h80000200) begin n_bad++; $display("FAIL b2b_hdr: got %b/%h want 1/80000200", tx_wr, tx_data); end
        tick();
        n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 32'h55AA55AA) begin n_bad++; $display("FAIL b2b_data: got %b/%h want 1/55aa55aa", tx_wr, tx_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_illegal_overrun();
        test_saturation();
        test_reset_mid_write();
        test_reset_blocked();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cfg_cmd_decoder.md
CFG_CMD_DECODER -- requirements
Module: cfg_cmd_decoder

Interface
REQ-001 SHALL provide parameter RD_LATENCY, default 1, meaning the number of clk cycles from the rd pulse to valid din (legal range 1..4).
REQ-002 SHALL provide port clk, input, 1, the single clock, the dsp_clk domain; all logic is on its rising edge.
REQ-003 SHALL provide port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL provide port rx_ready, input, 1, a one-cycle strobe marking each valid received UDP payload word.
REQ-005 SHALL provide port rx_data, input, 32, the received payload word, valid when rx_ready=1.
REQ-006 SHALL provide port tx_full, input, 1, the response FIFO full flag.
REQ-007 SHALL provide port tx_wr, output, 1, the response FIFO write strobe.
REQ-008 SHALL provide port tx_data, output, 32, the response word, valid when tx_wr=1.
REQ-009 SHALL provide port address, output, 16, the register address for wr/rd.
REQ-010 SHALL provide port wr, output, 1, a one-cycle register write strobe.
REQ-011 SHALL provide port rd, output, 1, a one-cycle register read strobe.
REQ-012 SHALL provide port dout, output, 32, the register write data, valid when wr=1.
REQ-013 SHALL provide port din, input, 32, the register read data, sampled RD_LATENCY cycles after rd.
REQ-014 SHALL provide port err_count, output, 8, a saturating count of illegal or dropped words.

Function
REQ-015 SHALL decode command words as: bits[31:30] opcode (01=write, 10=read, 00/11=illegal), bits[29:16] ignored, bits[15:0] address.
REQ-016 SHALL implement FSM states IDLE, WR_DATA, WR_ACK, RD_WAIT, RESP_HDR and RESP_DATA, with IDLE as the reset state.
REQ-017 SHALL, in IDLE on rx_ready with opcode 01, latch the address and go to WR_DATA.
REQ-018 SHALL, in IDLE on rx_ready with opcode 10, latch the address, pulse rd for exactly 1 cycle on the next cycle, and go to RD_WAIT.
REQ-019 SHALL, in IDLE on rx_ready with an illegal opcode, stay in IDLE and increment err_count.
REQ-020 SHALL, in WR_DATA on rx_ready, drive dout=rx_data and pulse wr for 1 cycle on the next cycle, with address stable, then go to WR_ACK.
REQ-021 SHALL, in WR_ACK, emit one response word {2'b01,14'h0,address}, then return to IDLE.
REQ-022 SHALL, in RD_WAIT, count RD_LATENCY cycles after the rd pulse, capture din into a 32-bit holding register, and go to RESP_HDR.
REQ-023 SHALL, in RESP_HDR, emit {2'b10,14'h0,address} and then go to RESP_DATA.
REQ-024 SHALL, in RESP_DATA, emit the captured read data and then return to IDLE.
REQ-025 SHALL assert tx_wr only in cycles where tx_full=0; while tx_full=1 the FSM holds its state and tx_data holds its value.
REQ-026 SHALL keep address stable from latch until the FSM next leaves IDLE.
REQ-027 SHALL keep wr and rd mutually exclusive and never high in consecutive cycles.
REQ-028 SHALL, on rx_ready in any state other than IDLE or WR_DATA, discard the word and increment err_count (overrun).
REQ-029 SHALL saturate err_count at 8'hFF with no wrap.
REQ-030 SHALL give a 2-cycle latency from the command rx_ready to the rd pulse, and from the data rx_ready to the wr pulse.
REQ-031 SHALL, with tx_full=0 throughout, assert the read response header exactly RD_LATENCY+2 cycles after the rd pulse and the data word on the following cycle.

Reset
REQ-032 SHALL, while reset=1, force state=IDLE, tx_wr=0, wr=0, rd=0, tx_data=0, address=0, dout=0 and err_count=0.
REQ-033 SHALL, when reset is asserted mid-transaction (including while blocked on tx_full), abandon the transaction with no further wr, rd or tx_wr after the reset edge.

Verification
REQ-034 SHALL cover write: rx 0x40000012 then 0xDEADBEEF -> wr=1 for 1 cycle with address=0x0012 and dout=0xDEADBEEF, then tx_data=0x40000012.
REQ-035 SHALL cover read: rx 0x80000034 with din=0x12345678 -> rd pulse at address 0x0034, then tx words 0x80000034 and 0x12345678 in consecutive cycles.
REQ-036 SHALL cover backpressure: tx_full=1 for 10 cycles during RESP_HDR -> no tx_wr during the stall, and both words are delivered in order after release.
REQ-037 SHALL cover illegal and overrun input: rx 0xC0000001, then a read followed by a rx word during RD_WAIT -> err_count=2, and the read response is unaffected.
REQ-038 SHALL cover saturation: 300 illegal words -> err_count=0xFF.
REQ-039 SHALL cover reset mid-operation: reset asserted in WR_DATA, then rx 0x11111111 -> no wr, and the word is treated as an illegal command (err_count=1).
